// File: rtl/astra_pkg.sv
// Shared types and constants for the core's bus-side blocks (memory arbiter FSM state, fetch lane mask).
package astra_pkg;

   localparam int unsigned ARB_DATA_W = 32;
   localparam int unsigned ARB_SEL_W  = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_INSTR = 2'd1,
      ARB_DATA  = 2'd2
   } arb_state_t;

   // Instruction fetches always read a full word.
   localparam logic [ARB_SEL_W-1:0] ARB_FETCH_SEL = 4'b1111;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for mem_arbiter; grant is one-hot {data, instr}.
// ARB_ROUND_ROBIN_EN selects round-robin on contention, otherwise data has fixed priority.
module arb_pick (
   input  logic       i_req_i,
   input  logic       i_req_d,
   input  logic       i_last_d,
   output logic [1:0] o_grant_c
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      o_grant_c = 2'b00;
      if (i_req_i && i_req_d) begin
         // Contention: serve the port that was not served last.
         o_grant_c = i_last_d ? 2'b01 : 2'b10;
      end else if (i_req_d) begin
         o_grant_c = 2'b10;
      end else if (i_req_i) begin
         o_grant_c = 2'b01;
      end
   end
`else
   logic w_unused_last;
   assign w_unused_last = i_last_d;

   always_comb begin
      o_grant_c = 2'b00;
      if (i_req_d) begin
         o_grant_c = 2'b10;
      end else if (i_req_i) begin
         o_grant_c = 2'b01;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch, data) to one memory port arbiter with STROBE/ACK handshake.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_arbiter
   import astra_pkg::*;
#(
   parameter int unsigned Addrsz = 32
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [Addrsz-1:0]     I_ADDR,
   input  logic                  I_STROBE,
   output logic [ARB_DATA_W-1:0] I_IN,
   output logic                  I_ACK,
   input  logic [Addrsz-1:0]     D_ADDR,
   input  logic [ARB_DATA_W-1:0] D_OUT,
   input  logic [ARB_SEL_W-1:0]  D_SEL,
   input  logic                  D_WE,
   input  logic                  D_STROBE,
   output logic [ARB_DATA_W-1:0] D_IN,
   output logic                  D_ACK,
   output logic [Addrsz-1:0]     M_ADDR,
   output logic [ARB_DATA_W-1:0] M_OUT,
   output logic [ARB_SEL_W-1:0]  M_SEL,
   output logic                  M_WE,
   output logic                  M_STROBE,
   input  logic [ARB_DATA_W-1:0] M_IN,
   input  logic                  M_ACK
);

   arb_state_t              r_state;
   arb_state_t              w_state_nxt;
   logic [1:0]              w_grant_c;
   logic                    w_last_d;

   logic [Addrsz-1:0]       r_m_addr;
   logic [ARB_DATA_W-1:0]   r_m_out;
   logic [ARB_SEL_W-1:0]    r_m_sel;
   logic                    r_m_we;
   logic                    r_m_strobe;

   logic [Addrsz-1:0]       w_m_addr_nxt;
   logic [ARB_DATA_W-1:0]   w_m_out_nxt;
   logic [ARB_SEL_W-1:0]    w_m_sel_nxt;
   logic                    w_m_we_nxt;

   arb_pick u_pick (
      .i_req_i   (I_STROBE),
      .i_req_d   (D_STROBE),
      .i_last_d  (w_last_d),
      .o_grant_c (w_grant_c)
   );

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_d;

   // Last-served pointer: 0 = instruction, 1 = data.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_last_d <= 1'b0;
      end else if (r_state == ARB_IDLE && w_grant_c != 2'b00) begin
         r_last_d <= w_grant_c[1];
      end
   end

   assign w_last_d = r_last_d;
`else
   assign w_last_d = 1'b0;
`endif

   // State and memory-port registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state    <= ARB_IDLE;
         r_m_addr   <= '0;
         r_m_out    <= '0;
         r_m_sel    <= '0;
         r_m_we     <= 1'b0;
         r_m_strobe <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_m_addr   <= w_m_addr_nxt;
         r_m_out    <= w_m_out_nxt;
         r_m_sel    <= w_m_sel_nxt;
         r_m_we     <= w_m_we_nxt;
         r_m_strobe <= (w_state_nxt != ARB_IDLE);
      end
   end

   // Next-state: grant from idle, return to idle on memory ack.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_grant_c[1]) begin
               w_state_nxt = ARB_DATA;
            end else if (w_grant_c[0]) begin
               w_state_nxt = ARB_INSTR;
            end
         end
         ARB_INSTR, ARB_DATA: begin
            if (M_ACK) begin
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // Output next values: latch the winner's qualifiers only when leaving idle.
   always_comb begin
      w_m_addr_nxt = r_m_addr;
      w_m_out_nxt  = r_m_out;
      w_m_sel_nxt  = r_m_sel;
      w_m_we_nxt   = r_m_we;
      if (r_state == ARB_IDLE) begin
         if (w_grant_c[1]) begin
            w_m_addr_nxt = D_ADDR;
            w_m_out_nxt  = D_OUT;
            w_m_sel_nxt  = D_SEL;
            w_m_we_nxt   = D_WE;
         end else if (w_grant_c[0]) begin
            w_m_addr_nxt = I_ADDR;
            w_m_out_nxt  = '0;
            w_m_sel_nxt  = ARB_FETCH_SEL;
            w_m_we_nxt   = 1'b0;
         end
      end
   end

   assign M_ADDR   = r_m_addr;
   assign M_OUT    = r_m_out;
   assign M_SEL    = r_m_sel;
   assign M_WE     = r_m_we;
   assign M_STROBE = r_m_strobe;

   // Zero-latency return path to the granted requester.
   assign I_ACK = M_ACK && (r_state == ARB_INSTR);
   assign D_ACK = M_ACK && (r_state == ARB_DATA);
   assign I_IN  = M_IN;
   assign D_IN  = M_IN;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (works with or without ARB_ROUND_ROBIN_EN).
module tb_mem_arbiter;

   logic        CLK;
   logic        RST_N;
   logic [31:0] I_ADDR;
   logic        I_STROBE;
   logic [31:0] I_IN;
   logic        I_ACK;
   logic [31:0] D_ADDR;
   logic [31:0] D_OUT;
   logic [3:0]  D_SEL;
   logic        D_WE;
   logic        D_STROBE;
   logic [31:0] D_IN;
   logic        D_ACK;
   logic [31:0] M_ADDR;
   logic [31:0] M_OUT;
   logic [3:0]  M_SEL;
   logic        M_WE;
   logic        M_STROBE;
   logic [31:0] M_IN;
   logic        M_ACK;

   int n_checks = 0;
   int n_pass   = 0;

   mem_arbiter #(.Addrsz(32)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .I_ADDR   (I_ADDR),
      .I_STROBE (I_STROBE),
      .I_IN     (I_IN),
      .I_ACK    (I_ACK),
      .D_ADDR   (D_ADDR),
      .D_OUT    (D_OUT),
      .D_SEL    (D_SEL),
      .D_WE     (D_WE),
      .D_STROBE (D_STROBE),
      .D_IN     (D_IN),
      .D_ACK    (D_ACK),
      .M_ADDR   (M_ADDR),
      .M_OUT    (M_OUT),
      .M_SEL    (M_SEL),
      .M_WE     (M_WE),
      .M_STROBE (M_STROBE),
      .M_IN     (M_IN),
      .M_ACK    (M_ACK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Enters a grant from idle, acks it with zero wait, checks routing and the idle bubble.
   task automatic grant_round(input string tag, input bit exp_d, input bit drop);
      logic [31:0] rdata;
      rdata = exp_d ? 32'hCAFE_0001 : 32'h0000_0013;
      tick();
      check({tag, "_strobe"}, 32'(M_STROBE), 32'd1);
      check({tag, "_addr"}, M_ADDR, exp_d ? 32'h0000_2000 : 32'h0000_0100);
      check({tag, "_sel"}, 32'(M_SEL), 32'hF);
      M_ACK = 1'b1;
      M_IN  = rdata;
      if (drop) begin
         if (exp_d) D_STROBE = 1'b0;
         else       I_STROBE = 1'b0;
      end
      #1;
      check({tag, "_dack"}, 32'(D_ACK), 32'(exp_d));
      check({tag, "_iack"}, 32'(I_ACK), 32'(!exp_d));
      check({tag, "_rdata"}, exp_d ? D_IN : I_IN, rdata);
      tick();
      M_ACK = 1'b0;
      #1;
      check({tag, "_bubble"}, 32'(M_STROBE), 32'd0);
   endtask

   initial begin
      RST_N = 1'b0;
      I_ADDR = '0; I_STROBE = 1'b0;
      D_ADDR = '0; D_OUT = '0; D_SEL = '0; D_WE = 1'b0; D_STROBE = 1'b0;
      M_IN = '0; M_ACK = 1'b0;
      tick();
      tick();
      check("rst_strobe", 32'(M_STROBE), 32'd0);
      check("rst_addr", M_ADDR, 32'd0);
      check("rst_out", M_OUT, 32'd0);
      check("rst_sel", 32'(M_SEL), 32'd0);
      check("rst_we", 32'(M_WE), 32'd0);
      check("rst_iack", 32'(I_ACK), 32'd0);
      check("rst_dack", 32'(D_ACK), 32'd0);
      RST_N = 1'b1;

      // Lone fetch with two wait cycles.
      I_ADDR = 32'h100; I_STROBE = 1'b1;
      #1;
      check("fetch_lat0", 32'(M_STROBE), 32'd0);
      tick();
      check("fetch_strobe", 32'(M_STROBE), 32'd1);
      check("fetch_addr", M_ADDR, 32'h100);
      check("fetch_sel", 32'(M_SEL), 32'hF);
      check("fetch_we", 32'(M_WE), 32'd0);
      check("fetch_out", M_OUT, 32'd0);
      check("fetch_wait1", 32'(I_ACK), 32'd0);
      tick();
      check("fetch_wait2", 32'(I_ACK), 32'd0);
      check("fetch_hold", 32'(M_STROBE), 32'd1);
      tick();
      M_ACK = 1'b1; M_IN = 32'h0000_0013; I_STROBE = 1'b0;
      #1;
      check("fetch_iack", 32'(I_ACK), 32'd1);
      check("fetch_iin", I_IN, 32'h0000_0013);
      check("fetch_dack", 32'(D_ACK), 32'd0);
      tick();
      M_ACK = 1'b0;
      #1;
      check("fetch_done", 32'(M_STROBE), 32'd0);
      check("fetch_iack_off", 32'(I_ACK), 32'd0);

      // Lone store, zero-wait memory.
      D_ADDR = 32'h2004; D_OUT = 32'hDEAD_BEEF; D_SEL = 4'h3; D_WE = 1'b1; D_STROBE = 1'b1;
      tick();
      check("store_addr", M_ADDR, 32'h2004);
      check("store_out", M_OUT, 32'hDEAD_BEEF);
      check("store_sel", 32'(M_SEL), 32'h3);
      check("store_we", 32'(M_WE), 32'd1);
      check("store_dack0", 32'(D_ACK), 32'd0);
      M_ACK = 1'b1; D_STROBE = 1'b0;
      #1;
      check("store_dack", 32'(D_ACK), 32'd1);
      check("store_iack", 32'(I_ACK), 32'd0);
      tick();
      M_ACK = 1'b0;
      #1;
      check("store_done", 32'(M_STROBE), 32'd0);

      // Simultaneous fetch and load; the last grant was data.
      I_ADDR = 32'h100; I_STROBE = 1'b1;
      D_ADDR = 32'h2000; D_SEL = 4'hF; D_WE = 1'b0; D_STROBE = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      grant_round("sim1", 1'b0, 1'b1);
      grant_round("sim2", 1'b1, 1'b1);
`else
      grant_round("sim1", 1'b1, 1'b1);
      grant_round("sim2", 1'b0, 1'b1);
`endif

      // Early strobe drop still completes and acks.
      D_ADDR = 32'h2000; D_STROBE = 1'b1;
      tick();
      D_STROBE = 1'b0;
      tick();
      check("early_strobe", 32'(M_STROBE), 32'd1);
      check("early_addr", M_ADDR, 32'h2000);
      M_ACK = 1'b1;
      #1;
      check("early_dack", 32'(D_ACK), 32'd1);
      tick();
      M_ACK = 1'b0;

      // Stray ack in idle.
      M_ACK = 1'b1;
      #1;
      check("stray_iack", 32'(I_ACK), 32'd0);
      check("stray_dack", 32'(D_ACK), 32'd0);
      tick();
      M_ACK = 1'b0;
      #1;
      check("stray_idle", 32'(M_STROBE), 32'd0);

      // Reset during a data grant.
      D_ADDR = 32'h3000; D_STROBE = 1'b1;
      tick();
      check("rmid_strobe", 32'(M_STROBE), 32'd1);
      RST_N = 1'b0; D_STROBE = 1'b0;
      tick();
      check("rmid_strobe0", 32'(M_STROBE), 32'd0);
      check("rmid_addr0", M_ADDR, 32'd0);
      RST_N = 1'b1; M_ACK = 1'b1;
      #1;
      check("rmid_late_dack", 32'(D_ACK), 32'd0);
      tick();
      M_ACK = 1'b0;
      #1;
      check("rmid_idle", 32'(M_STROBE), 32'd0);

`ifdef ARB_ROUND_ROBIN_EN
      // Pointer is back to instruction: contention alternates starting with data.
      I_ADDR = 32'h100; I_STROBE = 1'b1;
      D_ADDR = 32'h2000; D_SEL = 4'hF; D_WE = 1'b0; D_STROBE = 1'b1;
      for (int r = 0; r < 6; r++) begin
         grant_round($sformatf("rr%0d", r), (r % 2) == 0, 1'b0);
      end
      I_STROBE = 1'b0; D_STROBE = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
